// File: rtl/pdm_cic_decimator.sv
// CIC decimator: 1-bit PDM stream in, signed fixed-point samples out at 1/2**LOG2_DECIM rate.
// Integrators run on every PDM strobe; combs run once per decimated sample, fully pipelined.
module pdm_cic_decimator #(
  parameter int unsigned ORDER      = 4,
  parameter int unsigned LOG2_DECIM = 4,
  parameter int unsigned OUT_W      = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    pdm_valid_in,
  input  logic                    pdm_bit_in,
  output logic                    sample_valid_out,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    clip_out
);

  localparam int unsigned REG_W = ORDER * LOG2_DECIM + 2;
  localparam int          SHIFT = int'(ORDER * LOG2_DECIM + 1) - int'(OUT_W);
  localparam int          NST   = int'(ORDER);

  if (SHIFT < 0) begin : g_bad_shift
    $error("pdm_cic_decimator: OUT_W too wide for ORDER*LOG2_DECIM+1");
  end
  if (ORDER < 1 || ORDER > 6) begin : g_bad_order
    $error("pdm_cic_decimator: ORDER must be 1..6");
  end

  // Saturation bounds expressed at the internal register width
  localparam logic signed [REG_W-1:0] SAT_MAX = {{(REG_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [REG_W-1:0] SAT_MIN = {{(REG_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [REG_W-1:0]      integ_q [ORDER];
  logic [LOG2_DECIM-1:0] cnt_q;
  logic                  dec_q;
  logic [REG_W-1:0]      cap_q;
  logic                  cap_vld_q;
  logic [REG_W-1:0]      comb_q    [ORDER];
  logic [REG_W-1:0]      comb_prev_q [ORDER];
  logic                  comb_vld_q [ORDER];

  logic [REG_W-1:0]        in_map;
  logic [REG_W-1:0]        comb_in  [ORDER];
  logic                    comb_vin [ORDER];
  logic signed [REG_W-1:0] shifted;
  logic signed [OUT_W-1:0] sample_d;
  logic                    clip_d;

  // +1 for a one bit, -1 (all ones) for a zero bit
  assign in_map = pdm_bit_in ? REG_W'(1) : '1;

  // Integrator cascade; each stage adds the previous stage's registered value (wrap intended)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < NST; k++) integ_q[k] <= '0;
    end else if (pdm_valid_in) begin
      integ_q[0] <= integ_q[0] + in_map;
      for (int k = 1; k < NST; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
    end
  end

  // Decimation counter; flags the strobe that completes a frame
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      dec_q <= 1'b0;
    end else begin
      dec_q <= pdm_valid_in && (cnt_q == '1);
      if (pdm_valid_in) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Capture the last integrator one cycle after the decimating strobe updated it
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= dec_q;
      if (dec_q) cap_q <= integ_q[NST-1];
    end
  end

  // Comb stage inputs: stage 0 takes the captured sample, stage k the output of stage k-1
  always_comb begin
    comb_in[0]  = cap_q;
    comb_vin[0] = cap_vld_q;
    for (int k = 1; k < NST; k++) begin
      comb_in[k]  = comb_q[k-1];
      comb_vin[k] = comb_vld_q[k-1];
    end
  end

  // Comb pipeline, one differentiator per cycle; delay elements advance only on valid
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < NST; k++) begin
        comb_q[k]      <= '0;
        comb_prev_q[k] <= '0;
        comb_vld_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NST; k++) begin
        comb_vld_q[k] <= comb_vin[k];
        if (comb_vin[k]) begin
          comb_q[k]      <= comb_in[k] - comb_prev_q[k];
          comb_prev_q[k] <= comb_in[k];
        end
      end
    end
  end

  // Scale down by SHIFT and saturate to the output range
  always_comb begin
    shifted  = $signed(comb_q[NST-1]) >>> SHIFT;
    clip_d   = 1'b0;
    sample_d = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      sample_d = SAT_MAX[OUT_W-1:0];
      clip_d   = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sample_d = SAT_MIN[OUT_W-1:0];
      clip_d   = 1'b1;
    end
  end

  // Registered output; sample held between pulses, clip only qualified by the pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sample_valid_out <= 1'b0;
      sample_out       <= '0;
      clip_out         <= 1'b0;
    end else begin
      sample_valid_out <= comb_vld_q[NST-1];
      clip_out         <= comb_vld_q[NST-1] && clip_d;
      if (comb_vld_q[NST-1]) sample_out <= sample_d;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator at default parameters (ORDER=4, R=16, OUT_W=16).
module tb_pdm_cic_decimator;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic               pdm_valid_in = 1'b0;
  logic               pdm_bit_in = 1'b0;
  logic               sample_valid_out;
  logic signed [15:0] sample_out;
  logic               clip_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int samp_q[$];
  int clip_q[$];
  int pcyc_q[$];
  int scyc_q[$];

  pdm_cic_decimator dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pdm_valid_in     (pdm_valid_in),
    .pdm_bit_in       (pdm_bit_in),
    .sample_valid_out (sample_valid_out),
    .sample_out       (sample_out),
    .clip_out         (clip_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Collect every output pulse away from the active edge
  always @(negedge clk_in) begin
    if (sample_valid_out) begin
      samp_q.push_back(int'(sample_out));
      clip_q.push_back(int'(clip_out));
      pcyc_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    samp_q.delete();
    clip_q.delete();
    pcyc_q.delete();
    scyc_q.delete();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    pdm_valid_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    clear_logs();
  endtask

  task automatic strobe(input logic b, input int gap);
    pdm_bit_in = b;
    pdm_valid_in = 1'b1;
    @(posedge clk_in); #1;
    scyc_q.push_back(cyc);
    pdm_valid_in = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic flush();
    repeat (12) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_reset();
    pdm_bit_in = 1'b1;
    pdm_valid_in = 1'b1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    pdm_valid_in = 1'b0;
    clear_logs();
    checks++;
    if (sample_valid_out !== 1'b0 || sample_out !== 16'sd0 || clip_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b sample=%0d clip=%0b, required 0/0/0",
               sample_valid_out, sample_out, clip_out);
    end
  endtask

  task automatic test_all_ones();
    do_reset();
    for (int i = 0; i < 200; i++) strobe(1'b1, 32);
    flush();
    checks++;
    if (samp_q.size() != 12) begin
      errors++;
      $display("FAIL ones_count: got %0d pulses, required 12", samp_q.size());
    end
    if (samp_q.size() >= 2) begin
      checks++;
      if (samp_q[0] != 910 || clip_q[0] != 0) begin
        errors++;
        $display("FAIL ones_warmup0: got %0d clip %0d, required 910 clip 0", samp_q[0], clip_q[0]);
      end
      checks++;
      if (samp_q[1] != 14340) begin
        errors++;
        $display("FAIL ones_warmup1: got %0d, required 14340", samp_q[1]);
      end
    end
    for (int i = 4; i < samp_q.size(); i++) begin
      checks++;
      if (samp_q[i] != 32767 || clip_q[i] != 1) begin
        errors++;
        $display("FAIL ones_settled[%0d]: got %0d clip %0d, required 32767 clip 1",
                 i, samp_q[i], clip_q[i]);
      end
    end
  endtask

  task automatic test_all_zeros();
    do_reset();
    for (int i = 0; i < 160; i++) strobe(1'b0, 4);
    flush();
    checks++;
    if (samp_q.size() != 10) begin
      errors++;
      $display("FAIL zeros_count: got %0d pulses, required 10", samp_q.size());
    end
    if (samp_q.size() >= 1) begin
      checks++;
      if (samp_q[0] != -910) begin
        errors++;
        $display("FAIL zeros_warmup0: got %0d, required -910", samp_q[0]);
      end
    end
    for (int i = 4; i < samp_q.size(); i++) begin
      checks++;
      if (samp_q[i] != -32768 || clip_q[i] != 0) begin
        errors++;
        $display("FAIL zeros_settled[%0d]: got %0d clip %0d, required -32768 clip 0",
                 i, samp_q[i], clip_q[i]);
      end
    end
  endtask

  task automatic test_patterns();
    do_reset();
    for (int i = 0; i < 160; i++) strobe(((i % 2) == 0), 3);
    flush();
    checks++;
    if (samp_q.size() != 10) begin
      errors++;
      $display("FAIL alt_count: got %0d pulses, required 10", samp_q.size());
    end
    for (int i = 4; i < samp_q.size(); i++) begin
      checks++;
      if (samp_q[i] != 0 || clip_q[i] != 0) begin
        errors++;
        $display("FAIL alt_settled[%0d]: got %0d clip %0d, required 0 clip 0",
                 i, samp_q[i], clip_q[i]);
      end
    end
    do_reset();
    for (int i = 0; i < 160; i++) strobe(((i % 4) != 3), 3);
    flush();
    for (int i = 4; i < samp_q.size(); i++) begin
      checks++;
      if (samp_q[i] != 16384 || clip_q[i] != 0) begin
        errors++;
        $display("FAIL d075_settled[%0d]: got %0d clip %0d, required 16384 clip 0",
                 i, samp_q[i], clip_q[i]);
      end
    end
  endtask

  task automatic check_timing(input string name, input int npulse);
    checks++;
    if (pcyc_q.size() != npulse) begin
      errors++;
      $display("FAIL %s_count: got %0d pulses, required %0d", name, pcyc_q.size(), npulse);
    end
    for (int j = 0; j < pcyc_q.size(); j++) begin
      if (16 * (j + 1) - 1 < scyc_q.size()) begin
        checks++;
        if (pcyc_q[j] - scyc_q[16*(j+1)-1] != 6) begin
          errors++;
          $display("FAIL %s_latency[%0d]: got %0d cycles, required 6", name, j,
                   pcyc_q[j] - scyc_q[16*(j+1)-1]);
        end
      end
    end
  endtask

  task automatic test_timing();
    do_reset();
    for (int i = 0; i < 64; i++) strobe(1'b1, 8);
    flush();
    check_timing("sparse", 4);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 64; i++) strobe(((i % 3) == 0), 1);
    flush();
    check_timing("b2b", 4);
    // Long run so the integrators wrap many times
    do_reset();
    for (int i = 0; i < 20000; i++) strobe(1'b1, 1);
    flush();
    checks++;
    if (samp_q.size() != 1250) begin
      errors++;
      $display("FAIL wrap_count: got %0d pulses, required 1250", samp_q.size());
    end
    for (int i = 4; i < samp_q.size(); i++) begin
      checks++;
      if (samp_q[i] != 32767 || clip_q[i] != 1) begin
        errors++;
        $display("FAIL wrap_settled[%0d]: got %0d clip %0d, required 32767 clip 1",
                 i, samp_q[i], clip_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 23; i++) strobe(1'b1, 4);
    flush();
    checks++;
    if (sample_out !== 16'sd910) begin
      errors++;
      $display("FAIL midrst_hold: got %0d, required 910", sample_out);
    end
    // Reset coincides with a strobe; the bit must be discarded
    pdm_bit_in = 1'b1;
    pdm_valid_in = 1'b1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    pdm_valid_in = 1'b0;
    clear_logs();
    checks++;
    if (sample_valid_out !== 1'b0 || sample_out !== 16'sd0 || clip_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%0b sample=%0d clip=%0b, required 0/0/0",
               sample_valid_out, sample_out, clip_out);
    end
    for (int i = 0; i < 15; i++) strobe(1'b1, 4);
    flush();
    checks++;
    if (samp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_early: got %0d pulses after 15 strobes, required 0", samp_q.size());
    end
    strobe(1'b1, 4);
    flush();
    check_timing("midrst", 1);
    if (samp_q.size() == 1) begin
      checks++;
      if (samp_q[0] != 910) begin
        errors++;
        $display("FAIL midrst_value: got %0d, required 910", samp_q[0]);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_patterns();
    test_timing();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
